// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access sequencer: frame layout, modes, FSM encoding.
package spi_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned CNT_W   = 11;

    // Frame field positions
    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;

    // The only SPI modes the downstream master is driven with
    localparam logic [MODE_W-1:0] MODE1 = 2'd1;
    localparam logic [MODE_W-1:0] MODE3 = 2'd3;

    // One-hot sequencer states
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_LAUNCH = 5'b00010,
        S_WAIT   = 5'b00100,
        S_RESP   = 5'b01000,
        S_GUARD  = 5'b10000
    } state_t;

    // True for the modes the master supports
    function automatic logic mode_legal(input logic [MODE_W-1:0] mode);
        return (mode == MODE1) || (mode == MODE3);
    endfunction

    // Build the 16-bit frame: read flag, address, write data (zero for reads)
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [FRAME_W-1:0] frame;
        frame                     = '0;
        frame[RW_BIT]             = ~wr;
        frame[ADDR_MSB:ADDR_LSB]  = addr;
        frame[DATA_MSB:0]         = wr ? wdata : DATA_W'(0);
        return frame;
    endfunction

    // Saturating increment: the shared counter never wraps
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Request/response handshake between user logic and the SPI register sequencer.
interface spi_reg_ctrl_if;
    import spi_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [MODE_W-1:0]   req_mode;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    // User logic side: issues requests, consumes responses
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_mode,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Sequencer side: accepts requests, produces responses
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_mode,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer in front of the SPI master: formats frames, times the enable
// pulse, watches for completion and returns one response per request.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned EN_HOLD = 100,
    parameter int unsigned GAP     = 60,
    parameter int unsigned TIMEOUT = 2047
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    spi_reg_ctrl_if.slave        bus,
    output logic                 spi_en,
    output logic [MODE_W-1:0]    spi_mode,
    output logic [FRAME_W-1:0]   spi_sdata,
    input  logic [FRAME_W-1:0]   spi_rdata,
    input  logic                 spi_done
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Only the low byte of the returned frame carries register data
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^spi_rdata[FRAME_W-1:DATA_W];

    // Sequencer FSM; one shared counter times EN_HOLD, the watchdog and GAP
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            spi_en        <= 1'b0;
            spi_mode      <= MODE1;
            spi_sdata     <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        spi_sdata     <= build_frame(bus.req_wr, bus.req_addr, bus.req_wdata);
                        spi_mode      <= bus.req_mode;
                        cnt           <= CNT_W'(1);
                        if (mode_legal(bus.req_mode)) begin
                            state  <= S_LAUNCH;
                            spi_en <= 1'b1;
                        end else begin
                            // Illegal mode: answer immediately, the master is never enabled
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end
                    end
                end

                S_LAUNCH, S_WAIT: begin
                    cnt <= cnt_inc(cnt);
                    if (spi_done) begin
                        // Completion wins over watchdog and enable expiry on the same edge
                        spi_en        <= 1'b0;
                        state         <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= spi_sdata[RW_BIT] ? spi_rdata[DATA_MSB:0] : DATA_W'(0);
                    end else if (cnt >= CNT_W'(TIMEOUT)) begin
                        spi_en        <= 1'b0;
                        state         <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else if ((state == S_LAUNCH) && (cnt >= CNT_W'(EN_HOLD))) begin
                        spi_en <= 1'b0;
                        state  <= S_WAIT;
                    end
                end

                S_RESP: begin
                    state <= S_GUARD;
                    cnt   <= CNT_W'(1);
                end

                S_GUARD: begin
                    cnt <= cnt_inc(cnt);
                    if (cnt >= CNT_W'(GAP)) begin
                        state         <= S_IDLE;
                        bus.req_ready <= 1'b1;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    spi_en        <= 1'b0;
                    bus.req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl with a behavioural SPI master model.
module tb_spi_reg_ctrl;

    localparam int EN_HOLD = 100;
    localparam int GAP     = 60;
    localparam int TIMEOUT = 2047;

    logic        sys_clk;
    logic        rst_n;
    logic        spi_en;
    logic [1:0]  spi_mode;
    logic [15:0] spi_sdata;
    logic [15:0] spi_rdata;
    logic        spi_done;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl #(
        .EN_HOLD (EN_HOLD),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .spi_en    (spi_en),
        .spi_mode  (spi_mode),
        .spi_sdata (spi_sdata),
        .spi_rdata (spi_rdata),
        .spi_done  (spi_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Master model: counts frames, measures spi_en width, pulses spi_done after mdl_delay
    int          frames      = 0;
    int          en_width    = 0;
    int          done_edge   = 0;
    int          rsp_pulses  = 0;
    int          mdl_delay   = 150;
    int          dcnt        = 0;
    bit          busy        = 1'b0;
    bit          en_q        = 1'b0;
    bit          mdl_respond = 1'b1;
    logic [15:0] mdl_rdata   = 16'h0000;

    initial begin
        spi_done  = 1'b0;
        spi_rdata = 16'h0000;
    end

    always @(negedge sys_clk) begin
        spi_done = 1'b0;
        if (spi_en) en_width++;
        if (spi_en && !en_q) begin
            frames++;
            en_width = 1;
            busy     = 1'b1;
            dcnt     = 1;
        end else if (busy) begin
            dcnt++;
        end
        en_q = spi_en;
        if (busy && dcnt >= mdl_delay) begin
            busy = 1'b0;
            if (mdl_respond) begin
                spi_done  = 1'b1;
                spi_rdata = mdl_rdata;
                done_edge = cyc + 1;
            end
        end
        if (bus.rsp_valid) rsp_pulses++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a request, wait for acceptance; acc = cycle at which accepted outputs are visible
    task automatic send(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                        input logic [1:0] mode, input bit hold, output int acc);
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_mode  = mode;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (bus.req_ready) break;
            @(negedge sys_clk);
        end
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        @(negedge sys_clk);
        acc = cyc;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit got, output int rc,
                            output logic [7:0] rd, output logic e);
        got = 1'b0; rc = 0; rd = 8'h00; e = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rsp_valid) begin
                got = 1'b1; rc = cyc; rd = bus.rsp_rdata; e = bus.rsp_err;
                break;
            end
            @(negedge sys_clk);
        end
        chk("rsp_seen", 32'(got), 32'd1);
        @(negedge sys_clk);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic wait_ready(output int rdy);
        rdy = 0;
        for (int i = 0; i < 500; i++) begin
            if (bus.req_ready) begin
                rdy = cyc;
                break;
            end
            @(negedge sys_clk);
        end
        chk("ready_seen", 32'(bus.req_ready), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [1:0]  mode;
        logic [15:0] mdl_rdata;
        int          delay;
        logic [15:0] exp_sdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_frames;
        int          exp_width;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          acc, acc2, rc, rdy, fb, p0;
        bit          got;
        logic [7:0]  rd;
        logic        e;

        //               wr    addr   wdata  mode  mdl      dly  sdata     rdata  err  lat  frm width
        vecs[0] = '{1'b1, 7'h12, 8'hA5, 2'd1, 16'h0000, 150, 16'h12A5, 8'h00, 1'b0, 150, 1, 100};
        vecs[1] = '{1'b0, 7'h05, 8'h3C, 2'd3, 16'h00C3, 150, 16'h8500, 8'hC3, 1'b0, 150, 1, 100};
        vecs[2] = '{1'b0, 7'h7F, 8'h00, 2'd1, 16'hFF5A, 101, 16'hFF00, 8'h5A, 1'b0, 101, 1, 100};
        vecs[3] = '{1'b1, 7'h00, 8'hFF, 2'd3, 16'h1234, 200, 16'h00FF, 8'h00, 1'b0, 200, 1, 100};
        vecs[4] = '{1'b0, 7'h2A, 8'h00, 2'd1, 16'h0066,  40, 16'hAA00, 8'h66, 1'b0,  40, 1,  40};
        vecs[5] = '{1'b1, 7'h55, 8'h0F, 2'd3, 16'h0000, 100, 16'h550F, 8'h00, 1'b0, 100, 1, 100};
        vecs[6] = '{1'b1, 7'h33, 8'h11, 2'd2, 16'h0000, 150, 16'h3311, 8'h00, 1'b1,   0, 0,   0};
        vecs[7] = '{1'b0, 7'h01, 8'h77, 2'd0, 16'h0000, 150, 16'h8100, 8'h00, 1'b1,   0, 0,   0};

        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_mode  = 2'd1;
        rst_n         = 1'b0;

        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_spi_en",    32'(spi_en),        32'd0);
        chk("rst_spi_mode",  32'(spi_mode),      32'd1);
        chk("rst_spi_sdata", 32'(spi_sdata),     32'd0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Table-driven single transactions
        for (int v = 0; v < 8; v++) begin
            mdl_delay   = vecs[v].delay;
            mdl_rdata   = vecs[v].mdl_rdata;
            mdl_respond = 1'b1;
            fb          = frames;
            send(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].mode, 1'b0, acc);
            chk($sformatf("v%0d_sdata", v), 32'(spi_sdata), 32'(vecs[v].exp_sdata));
            chk($sformatf("v%0d_mode", v),  32'(spi_mode),  32'(vecs[v].mode));
            wait_rsp(3000, got, rc, rd, e);
            chk($sformatf("v%0d_rsp_lat", v), 32'(rc - acc), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_rdata", v),   32'(rd), 32'(vecs[v].exp_rdata));
            chk($sformatf("v%0d_err", v),     32'(e),  32'(vecs[v].exp_err));
            wait_ready(rdy);
            chk($sformatf("v%0d_ready_lat", v), 32'(rdy - rc), 32'(GAP + 1));
            chk($sformatf("v%0d_frames", v),    32'(frames - fb), 32'(vecs[v].exp_frames));
            if (vecs[v].exp_frames != 0)
                chk($sformatf("v%0d_en_width", v), 32'(en_width), 32'(vecs[v].exp_width));
        end

        // Watchdog: master never completes
        mdl_respond = 1'b0;
        mdl_delay   = 5000;
        send(1'b0, 7'h2A, 8'h00, 2'd1, 1'b0, acc);
        wait_rsp(2500, got, rc, rd, e);
        chk("to_rsp_lat", 32'(rc - acc), 32'(TIMEOUT));
        chk("to_err",     32'(e),  32'd1);
        chk("to_rdata",   32'(rd), 32'd0);
        chk("to_en_width", 32'(en_width), 32'(EN_HOLD));
        wait_ready(rdy);
        chk("to_ready_lat", 32'(rdy - rc), 32'(GAP + 1));
        mdl_respond = 1'b1;

        // Back-to-back with req_valid held high
        mdl_delay = 150;
        mdl_rdata = 16'h003E;
        fb        = frames;
        p0        = rsp_pulses;
        send(1'b1, 7'h10, 8'h01, 2'd1, 1'b1, acc);
        send(1'b0, 7'h11, 8'h00, 2'd3, 1'b0, acc2);
        chk("b2b_gap", 32'(acc2 - done_edge), 32'(GAP + 2));
        chk("b2b_sdata2", 32'(spi_sdata), 32'h9100);
        wait_rsp(3000, got, rc, rd, e);
        chk("b2b_rdata2", 32'(rd), 32'h3E);
        wait_ready(rdy);
        repeat (200) @(negedge sys_clk);
        chk("b2b_frames", 32'(frames - fb), 32'd2);
        chk("b2b_rsps",   32'(rsp_pulses - p0), 32'd2);

        // Reset while waiting for completion
        mdl_delay = 300;
        send(1'b1, 7'h22, 8'h5A, 2'd1, 1'b0, acc);
        repeat (150) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("mid_rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("mid_rst_spi_en",    32'(spi_en),        32'd0);
        chk("mid_rst_spi_mode",  32'(spi_mode),      32'd1);
        chk("mid_rst_spi_sdata", 32'(spi_sdata),     32'd0);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        p0 = rsp_pulses;
        repeat (200) @(negedge sys_clk);
        chk("late_done_seen",     32'(done_edge > acc + 150), 32'd1);
        chk("late_done_no_rsp",   32'(rsp_pulses - p0), 32'd0);
        mdl_delay = 120;
        mdl_rdata = 16'h0077;
        send(1'b0, 7'h40, 8'h00, 2'd3, 1'b0, acc);
        chk("post_rst_sdata", 32'(spi_sdata), 32'hC000);
        wait_rsp(3000, got, rc, rd, e);
        chk("post_rst_lat",   32'(rc - acc), 32'd120);
        chk("post_rst_rdata", 32'(rd), 32'h77);
        chk("post_rst_err",   32'(e),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
